// File: rtl/prog_loader_pkg.sv
// Shared types and sizing for the program loader.
// Optional checksum stage is enabled by defining PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;
  localparam int I_WIDTH         = 24;
  localparam int BYTES_PER_INSTR = (I_WIDTH + 7) / 8;

  typedef enum logic [2:0] {
    L_IDLE, L_LEN, L_DATA, L_WRITE, L_CHK, L_DONE
  } loader_state_t;
endpackage

// File: rtl/prog_loader_instr_packer.sv
// Packs an MSB-first byte stream into one instruction word; pad bits above
// DATA_WIDTH fall off the top of the shift register.
module instr_packer
  import prog_loader_pkg::*;
#(
  parameter int DATA_WIDTH = I_WIDTH,
  parameter int BYTES      = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  last_byte
);
  localparam int CW = $clog2(BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  logic [CW-1:0] cnt;

  assign last_byte = shift_en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      word <= DATA_WIDTH'({word, byte_in});
      cnt  <= last_byte ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: LEN byte, then N packed instructions written to
// successive addresses. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = I_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err
);
  localparam int BYTES = (DATA_WIDTH + 7) / 8;
  localparam int NW    = ADDR_WIDTH + 1;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam loader_state_t AFTER_LAST = L_CHK;
`else
  localparam loader_state_t AFTER_LAST = L_DONE;
`endif

  loader_state_t         state, state_nx;
  logic [NW-1:0]         n_q, wcnt;
  logic [DATA_WIDTH-1:0] word, wdata_q;
  logic                  acc, last_byte, last_word, start_acc;

  assign acc       = rx_valid & rx_ready;
  assign last_word = (wcnt == n_q - 1'b1);
  assign start_acc = (state == L_IDLE) && load_start;

  instr_packer #(.DATA_WIDTH(DATA_WIDTH), .BYTES(BYTES)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_acc),
    .shift_en  (acc && (state == L_DATA)),
    .byte_in   (rx_data),
    .word      (word),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= L_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rx_ready  = 1'b0;
    mem_we    = 1'b0;
    cpu_hold  = 1'b0;
    load_done = 1'b0;
    load_busy = (state != L_IDLE);
    case (state)
      L_IDLE:  if (load_start) state_nx = L_LEN;
      L_LEN: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        if (acc) state_nx = L_DATA;
      end
      L_DATA: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        if (last_byte) state_nx = L_WRITE;
      end
      L_WRITE: begin
        mem_we   = 1'b1;
        cpu_hold = 1'b1;
        state_nx = last_word ? AFTER_LAST : L_DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      L_CHK: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        if (acc) state_nx = L_DONE;
      end
`endif
      L_DONE: begin
        load_done = 1'b1;
        state_nx  = L_IDLE;
      end
      default: state_nx = L_IDLE;
    endcase
  end

  // Word counter doubles as the write address; it stops at N-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q     <= '0;
      wcnt    <= '0;
      wdata_q <= '0;
    end else begin
      if (start_acc) wcnt <= '0;
      if ((state == L_LEN) && acc)
        n_q <= (rx_data[NW-1:0] == '0) ? NW'(1 << ADDR_WIDTH) : rx_data[NW-1:0];
      if (state == L_WRITE) begin
        wdata_q <= word;
        if (!last_word) wcnt <= wcnt + 1'b1;
      end
    end
  end

  assign mem_addr  = wcnt[ADDR_WIDTH-1:0];
  assign mem_wdata = mem_we ? word : wdata_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (start_acc) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (acc && (state == L_DATA)) begin
      csum <= csum ^ rx_data;
    end else if (acc && (state == L_CHK) && (rx_data != csum)) begin
      err <= 1'b1;
    end
  end

  assign load_err = err;
`else
  assign load_err = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a byte-list reference model.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready, mem_we, cpu_hold, load_busy, load_done, load_err;
  logic [5:0]  mem_addr;
  logic [23:0] mem_wdata;

  logic        load_start20 = 1'b0, rx_valid20 = 1'b0;
  logic [7:0]  rx_data20 = '0;
  logic        rx_ready20, mem_we20, cpu_hold20, load_busy20, load_done20, load_err20;
  logic [5:0]  mem_addr20;
  logic [19:0] mem_wdata20;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err));

  prog_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(20)) dut20 (
    .clk(clk), .reset(reset), .load_start(load_start20), .rx_data(rx_data20),
    .rx_valid(rx_valid20), .rx_ready(rx_ready20), .mem_we(mem_we20), .mem_addr(mem_addr20),
    .mem_wdata(mem_wdata20), .cpu_hold(cpu_hold20), .load_busy(load_busy20),
    .load_done(load_done20), .load_err(load_err20));

  typedef struct { int addr; int data; } wr_t;
  wr_t        exp_q[$], got_q[$], e;
  logic [7:0] load_q[$];
  int errors = 0, checks = 0, nwrites = 0, ndone = 0;
  int w20_cnt = 0, w20_addr = 0, w20_data = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: N from LEN byte (7 bits, 0 -> 64), each word = 3 bytes big-endian.
  task automatic build_model(output logic [7:0] cs);
    logic [7:0] b0;
    int n, d;
    b0 = load_q[0];
    n  = int'(b0[6:0]);
    if (n == 0) n = 64;
    cs = 8'h00;
    for (int i = 1; i < load_q.size(); i++) cs = cs ^ load_q[i];
    for (int w = 0; w < n; w++) begin
      d = 0;
      for (int k = 0; k < 3; k++) d = (d << 8) | int'(load_q[1 + w*3 + k]);
      exp_q.push_back('{w, d & 32'hFFFFFF});
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        nwrites++;
        got_q.push_back('{int'(mem_addr), int'(mem_wdata)});
        chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %h, none required", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", {26'd0, mem_addr}, e.addr);
          chk("write_data", {8'd0, mem_wdata}, e.data);
        end
      end
      if (load_done) ndone++;
      if (mem_we20) begin
        w20_cnt++;
        w20_addr = int'(mem_addr20);
        w20_data = int'(mem_wdata20);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int pct, input bit noise);
    int  tries = 0;
    bit  got = 0;
    rx_data = b;
    while (!got) begin
      rx_valid = ($urandom_range(99) < pct);
      if (noise) load_start = ($urandom_range(3) == 0);
      @(negedge clk);
      if (rx_valid && rx_ready) got = 1;
      @(posedge clk); #1;
      tries++;
      if (!got && tries > 300) begin
        checks++;
        errors++;
        $display("FAIL byte_timeout: byte %h not accepted after %0d cycles", b, tries);
        got = 1;
      end
    end
    rx_valid   = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic run_load(input int pct, input bit noise, input bit bad);
    logic [7:0] cs;
    int n0w, n0d, nw, lat;
    build_model(cs);
    nw  = exp_q.size();
    n0w = nwrites;
    n0d = ndone;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    chk("busy_after_start", {31'd0, load_busy}, 32'd1);
    chk("err_cleared_on_start", {31'd0, load_err}, 32'd0);
    foreach (load_q[i]) send_byte(load_q[i], pct, noise);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(bad ? (cs ^ 8'h5A) : cs, pct, noise);
`endif
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!load_done && lat < 10);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("done_latency", lat, 1);
    chk("load_err", {31'd0, load_err}, {31'd0, bad});
`else
    chk("done_latency", lat, 2);
    chk("load_err_off", {31'd0, load_err}, 32'd0);
`endif
    chk("hold_at_done", {31'd0, cpu_hold}, 32'd0);
    @(posedge clk); #1;
    chk("busy_after_done", {31'd0, load_busy}, 32'd0);
    chk("hold_after_done", {31'd0, cpu_hold}, 32'd0);
    chk("write_count", nwrites - n0w, nw);
    chk("done_count", ndone - n0d, 1);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_we"},    {31'd0, mem_we}, 32'd0);
    chk({tag, "_addr"},  {26'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {8'd0, mem_wdata}, 32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_busy"},  {31'd0, load_busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, load_done}, 32'd0);
    chk({tag, "_err"},   {31'd0, load_err}, 32'd0);
    chk({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
  endtask

  task automatic send20(input logic [7:0] b);
    int tries = 0;
    rx_data20  = b;
    rx_valid20 = 1'b1;
    do begin
      @(negedge clk);
      tries++;
      if (!rx_ready20) begin @(posedge clk); #1; end
    end while (!rx_ready20 && tries < 20);
    chk("w20_byte_accepted", {31'd0, rx_ready20}, 32'd1);
    @(posedge clk); #1;
    rx_valid20 = 1'b0;
  endtask

  task automatic set_t1();
    load_q = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
  endtask

  initial begin
    logic [7:0] cs;
    int n0w, lat;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: basic two-word load, DUT writes pinned to literals
    set_t1();
    got_q.delete();
    run_load(100, 0, 0);
    chk("t1_nwrites", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("t1_addr0", got_q[0].addr, 0);
      chk("t1_data0", got_q[0].data, 32'h123456);
      chk("t1_addr1", got_q[1].addr, 1);
      chk("t1_data1", got_q[1].data, 32'hABCDEF);
    end

    // 2: N=0 means full depth
    load_q = '{8'h00};
    for (int i = 0; i < 192; i++) load_q.push_back(8'($urandom));
    got_q.delete();
    run_load(80, 0, 0);
    chk("t2_nwrites", got_q.size(), 64);
    if (got_q.size() == 64) chk("t2_last_addr", got_q[63].addr, 63);

    // 3: random valid gaps, load_start re-pulsed while busy
    set_t1();
    run_load(40, 1, 0);

    // 4: reset in the middle of the second word
    set_t1();
    build_model(cs);
    n0w = nwrites;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(load_q[i], 100, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero("midreset");
    reset = 1'b0;
    exp_q.delete();
    chk("midreset_writes", nwrites - n0w, 1);
    @(posedge clk); #1;
    set_t1();
    run_load(70, 0, 0);

    // random loads, LEN bit 7 set sometimes (must be truncated away)
    for (int r = 0; r < 4; r++) begin
      load_q = '{8'($urandom_range(1, 8) | ($urandom_range(1) << 7))};
      for (int i = 0; i < 3 * int'(load_q[0] & 8'h7F); i++) load_q.push_back(8'($urandom));
      run_load(60, r[0], r[1]);
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // 5: bad checksum sets the sticky error, next good load clears it
    set_t1();
    run_load(100, 0, 1);
    set_t1();
    run_load(100, 0, 0);
`endif

    // 6: 20-bit instructions drop the pad nibble of the first byte
    load_start20 = 1'b1;
    @(posedge clk); #1;
    load_start20 = 1'b0;
    send20(8'h01);
    send20(8'hFF);
    send20(8'h00);
    send20(8'h01);
`ifdef PROG_LOADER_CHECKSUM_EN
    send20(8'hFE);
`endif
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!load_done20 && lat < 10);
    chk("w20_done", {31'd0, load_done20}, 32'd1);
    chk("w20_count", w20_cnt, 1);
    chk("w20_addr", w20_addr, 0);
    chk("w20_data", w20_data, 32'hF0001);
    chk("w20_err", {31'd0, load_err20}, 32'd0);
    @(posedge clk); #1;

    chk("exp_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
